// File: rtl/frame_capture.sv
// Captures a RES x RES window of a DVI pixel stream as 8-bit luma into an on-chip
// buffer, with a three-stage write pipeline and a single-cycle readback port.
package dvi_pkg;
    localparam int X_POS_W = 12;
    localparam int Y_POS_W = 11;
    localparam int COLOR_W = 8;
endpackage

module frame_capture
    import dvi_pkg::*;
#(
    parameter int X_OFF = 20,
    parameter int Y_OFF = 20,
    parameter int RES   = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [X_POS_W-1:0]         x_i,
    input  logic [Y_POS_W-1:0]         y_i,
    input  logic                       de_i,
    input  logic [COLOR_W-1:0]         red_i,
    input  logic [COLOR_W-1:0]         green_i,
    input  logic [COLOR_W-1:0]         blue_i,
    input  logic                       start_i,
    input  logic                       rd_req_i,
    input  logic [2*$clog2(RES)-1:0]   rd_addr_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       rd_valid_o,
    output logic [7:0]                 rd_data_o
);

    localparam int AW     = $clog2(RES);
    localparam int ADDR_W = 2 * AW;
    localparam int DEPTH  = RES * RES;
    localparam int SUM_W  = COLOR_W + 2;

    localparam logic [X_POS_W-1:0] LP_X_LO = X_POS_W'(X_OFF);
    localparam logic [X_POS_W-1:0] LP_X_HI = X_POS_W'(X_OFF + RES - 1);
    localparam logic [Y_POS_W-1:0] LP_Y_LO = Y_POS_W'(Y_OFF);
    localparam logic [Y_POS_W-1:0] LP_Y_HI = Y_POS_W'(Y_OFF + RES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               w_origin;
    logic               w_cap_pix;
    logic               w_rd_ok;

    logic               r_s1_we;
    logic [X_POS_W-1:0] r_s1_x;
    logic [Y_POS_W-1:0] r_s1_y;
    logic [COLOR_W-1:0] r_s1_r;
    logic [COLOR_W-1:0] r_s1_g;
    logic [COLOR_W-1:0] r_s1_b;

    logic [SUM_W-1:0]   w_sum;
    logic [7:0]         w_luma;
    logic               w_in_win;
    logic               w_last;
    logic [AW-1:0]      w_x_rel;
    logic [AW-1:0]      w_y_rel;

    logic               r_we;
    logic               r_last;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_luma;

    logic [7:0]         r_mem [DEPTH];
    logic               r_rd_valid;
    logic [7:0]         r_rd_data;

    // The pixel that arms the capture is judged against the state it arrives in.
    assign w_origin  = (x_i == '0) && (y_i == '0);
    assign w_cap_pix = de_i && ((r_state == S_CAPTURE) || ((r_state == S_ARM) && w_origin));
    assign w_rd_ok   = rd_req_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = S_ARM;
            S_ARM:     if (de_i && w_origin) w_next = S_CAPTURE;
            S_CAPTURE: if (r_we && r_last) w_next = S_DONE;
            S_DONE:    if (start_i) w_next = S_ARM;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_ARM, S_CAPTURE: busy_o = 1'b1;
            S_DONE:           done_o = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_we <= 1'b0;
            r_s1_x  <= '0;
            r_s1_y  <= '0;
            r_s1_r  <= '0;
            r_s1_g  <= '0;
            r_s1_b  <= '0;
        end else begin
            r_s1_we <= w_cap_pix;
            r_s1_x  <= x_i;
            r_s1_y  <= y_i;
            r_s1_r  <= red_i;
            r_s1_g  <= green_i;
            r_s1_b  <= blue_i;
        end
    end

    assign w_sum    = SUM_W'(r_s1_r) + {1'b0, r_s1_g, 1'b0} + SUM_W'(r_s1_b);
    assign w_luma   = 8'(w_sum >> 2);
    assign w_in_win = (r_s1_x >= LP_X_LO) && (r_s1_x <= LP_X_HI) &&
                      (r_s1_y >= LP_Y_LO) && (r_s1_y <= LP_Y_HI);
    assign w_last   = (r_s1_x == LP_X_HI) && (r_s1_y == LP_Y_HI);
    // RES is a power of two, so row-major addressing is a plain concatenation.
    assign w_x_rel  = AW'(r_s1_x - LP_X_LO);
    assign w_y_rel  = AW'(r_s1_y - LP_Y_LO);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we   <= 1'b0;
            r_last <= 1'b0;
            r_addr <= '0;
            r_luma <= '0;
        end else begin
            r_we   <= r_s1_we && w_in_win;
            r_last <= w_last;
            r_addr <= {w_y_rel, w_x_rel};
            r_luma <= w_luma;
        end
    end

    // Buffer is deliberately not reset so a partial capture survives rst_ni.
    always_ff @(posedge clk_i) begin
        if (r_we) begin
            r_mem[r_addr] <= r_luma;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= r_mem[rd_addr_i];
            end
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a reduced raster (260x12) with an 8x8 window
// placed at x=250 so the luma gradient crosses the x[7:0] wrap inside the window.
module tb_frame_capture;
    import dvi_pkg::*;

    localparam int X_OFF = 250;
    localparam int Y_OFF = 2;
    localparam int RES   = 8;
    localparam int AW    = 3;
    localparam int XH    = X_OFF + RES - 1;
    localparam int YH    = Y_OFF + RES - 1;
    localparam int XT    = 260;
    localparam int YT    = 12;

    localparam int M_CONST = 0;
    localparam int M_GRAD  = 1;
    localparam int M_AA    = 2;
    localparam int M_EDGE  = 3;
    localparam int M_DEOFF = 4;

    logic               clk_i;
    logic               rst_ni;
    logic [X_POS_W-1:0] x_i;
    logic [Y_POS_W-1:0] y_i;
    logic               de_i;
    logic [COLOR_W-1:0] red_i;
    logic [COLOR_W-1:0] green_i;
    logic [COLOR_W-1:0] blue_i;
    logic               start_i;
    logic               rd_req_i;
    logic [2*AW-1:0]    rd_addr_i;
    logic               busy_o;
    logic               done_o;
    logic               rd_valid_o;
    logic [7:0]         rd_data_o;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int last_cyc  = 0;
    int rise_cyc  = 0;
    logic prev_done = 1'b0;

    frame_capture #(.X_OFF(X_OFF), .Y_OFF(Y_OFF), .RES(RES)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .x_i        (x_i),
        .y_i        (y_i),
        .de_i       (de_i),
        .red_i      (red_i),
        .green_i    (green_i),
        .blue_i     (blue_i),
        .start_i    (start_i),
        .rd_req_i   (rd_req_i),
        .rd_addr_i  (rd_addr_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (done_o && !prev_done) rise_cyc = cyc;
        prev_done = done_o;
    endtask

    task automatic set_pix(input int mode, input int x, input int y);
        x_i     = X_POS_W'(x);
        y_i     = Y_POS_W'(y);
        de_i    = (x == 0) && (y == 0);
        red_i   = '0;
        green_i = '0;
        blue_i  = '0;
        case (mode)
            M_CONST: begin de_i = 1'b1; red_i = 8'd40; green_i = 8'd80; blue_i = 8'd120; end
            M_GRAD:  begin de_i = 1'b1; red_i = 8'(x); green_i = 8'(x); blue_i = 8'(x); end
            M_AA:    begin de_i = 1'b1; red_i = 8'hAA; green_i = 8'hAA; blue_i = 8'hAA; end
            M_EDGE: begin
                if (x == X_OFF - 1 || x == X_OFF + RES) begin
                    de_i = 1'b1; red_i = 8'h55; green_i = 8'h55; blue_i = 8'h55;
                end
                if (x == XH && y == YH) begin
                    de_i = 1'b1; red_i = 8'hAA; green_i = 8'hAA; blue_i = 8'hAA;
                end
            end
            default: ;
        endcase
    endtask

    task automatic frame_rows(input int mode, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < XT; x++) begin
                set_pix(mode, x, y);
                tick();
                if (x == XH && y == YH) last_cyc = cyc;
            end
        end
        de_i = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [7:0] exp, input string tag);
        rd_addr_i = (2*AW)'(addr);
        rd_req_i  = 1'b1;
        tick();
        rd_req_i  = 1'b0;
        chk({tag, "_valid"}, rd_valid_o, 1);
        chk(tag, rd_data_o, exp);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; x_i = '0; y_i = '0; de_i = 1'b0;
        red_i = '0; green_i = '0; blue_i = '0;
        start_i = 1'b0; rd_req_i = 1'b0; rd_addr_i = '0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        rst_ni = 1'b1;
        repeat (3) tick();
        chk("idle_hold_busy", busy_o, 0);

        // Constant colour frame: luma (40+160+120)>>2 = 80 everywhere.
        pulse_start();
        chk("arm_busy", busy_o, 1);
        chk("arm_done", done_o, 0);
        rd_addr_i = '0; rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        chk("arm_rd_drop", rd_valid_o, 0);
        rise_cyc = 0;
        frame_rows(M_CONST, 0, YT - 1);
        chk("done_latency", rise_cyc - last_cyc, 2);
        chk("const_done", done_o, 1);
        chk("const_busy", busy_o, 0);
        for (int a = 0; a < RES * RES; a++) rd(a, 8'd80, $sformatf("const_a%0d", a));

        // Gradient: luma equals x[7:0]; x=256,257 wrap to 0,1.
        pulse_start();
        chk("restart_done_clr", done_o, 0);
        chk("restart_busy", busy_o, 1);
        frame_rows(M_GRAD, 0, YT - 1);
        rd(0, 8'd250, "grad_a0");
        rd(5, 8'd255, "grad_a5");
        rd(6, 8'd0,   "grad_a6");
        rd(7, 8'd1,   "grad_a7");
        rd(8, 8'd250, "grad_a8");
        tick();
        chk("hold_valid", rd_valid_o, 0);
        chk("hold_data", rd_data_o, 8'd250);

        // 0xAA fill, with a readback attempt dropped mid-capture.
        pulse_start();
        frame_rows(M_AA, 0, 4);
        rd_addr_i = 6'd9; rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        chk("cap_rd_drop", rd_valid_o, 0);
        chk("cap_busy", busy_o, 1);
        frame_rows(M_AA, 5, YT - 1);
        chk("aa_done", done_o, 1);
        rd(9, 8'hAA, "aa_a9");

        // start and rd_req together in DONE: read served, FSM arms.
        rd_addr_i = 6'd3; start_i = 1'b1; rd_req_i = 1'b1;
        tick();
        start_i = 1'b0; rd_req_i = 1'b0;
        chk("co_valid", rd_valid_o, 1);
        chk("co_data", rd_data_o, 8'hAA);
        chk("co_busy", busy_o, 1);
        chk("co_done", done_o, 0);

        // Only x=249 and x=258 carry 0x55; window edges must keep 0xAA.
        frame_rows(M_EDGE, 0, YT - 1);
        chk("edge_done", done_o, 1);
        for (int r = 0; r < RES; r++) begin
            rd(r * RES, 8'hAA, $sformatf("edge_l%0d", r));
            rd(r * RES + RES - 1, 8'hAA, $sformatf("edge_r%0d", r));
        end

        // de_i low across the window: capture never completes.
        pulse_start();
        frame_rows(M_DEOFF, 0, YT - 1);
        chk("deoff_busy", busy_o, 1);
        chk("deoff_done", done_o, 0);
        rd_addr_i = '0; rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        chk("deoff_rd_drop", rd_valid_o, 0);

        // Still capturing; new frame of 80 continues, reset after pixel (252,5).
        frame_rows(M_CONST, 0, 4);
        for (int x = 0; x <= 252; x++) begin
            set_pix(M_CONST, x, 5);
            tick();
        end
        de_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_valid", rd_valid_o, 0);
        chk("mid_rst_data", rd_data_o, 0);
        tick();
        rst_ni = 1'b1;
        set_pix(M_CONST, 0, 0);
        tick();
        de_i = 1'b0;
        tick();
        chk("post_rst_idle", busy_o, 0);
        rd(0,  8'd80,  "part_a0");
        rd(23, 8'd80,  "part_a23");
        rd(24, 8'd80,  "part_a24");
        rd(25, 8'hAA,  "part_a25_pending");
        rd(26, 8'hAA,  "part_a26_pending");
        rd(32, 8'hAA,  "part_a32");
        rd(63, 8'hAA,  "part_a63");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 The module SHALL have parameter X_OFF, default 20, left column of the capture window in screen pixels.
REQ-002 The module SHALL have parameter Y_OFF, default 20, top row of the capture window in screen pixels.
REQ-003 The module SHALL have parameter RES, default 256, window width and height; power of two; buffer depth is RES*RES bytes.
REQ-004 The module SHALL take widths X_POS_W, Y_POS_W and COLOR_W (8) from dvi_pkg.
REQ-005 The module SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk_i  in  1  pixel clock; sole clock
- rst_ni  in  1  asynchronous active-low reset
- x_i  in  X_POS_W  current pixel column
- y_i  in  Y_POS_W  current pixel row
- de_i  in  1  active-video qualifier for x_i/y_i/colour
- red_i, green_i, blue_i  in  COLOR_W each  pixel colour
- start_i  in  1  single-cycle pulse; arms a capture
- rd_req_i  in  1  single-cycle readback request
- rd_addr_i  in  2*log2(RES)  readback address, row-major
- busy_o  out  1  capture armed or in progress
- done_o  out  1  a complete window is held in the buffer
- rd_valid_o  out  1  rd_data_o valid this cycle
- rd_data_o  out  8  captured luma byte

Function
REQ-006 The window SHALL be X_OFF <= x_i <= X_OFF+RES-1 and Y_OFF <= y_i <= Y_OFF+RES-1, inclusive at both ends.
REQ-007 Luma SHALL be (red_i + 2*green_i + blue_i) >> 2, computed at 10 bits with no overflow, truncated to 8 bits.
REQ-008 The write address SHALL be (y_i-Y_OFF)*RES + (x_i-X_OFF).
REQ-009 Pipeline: cycle N samples the inputs; cycle N+1 registers luma, address and the in-window/write-enable flag; cycle N+2 writes the buffer.
REQ-010 The FSM SHALL have states IDLE, ARM, CAPTURE and DONE.
REQ-011 In IDLE or DONE, start_i SHALL move the FSM to ARM and clear done_o on the next cycle.
REQ-012 In ARM, de_i=1 with x_i=0 and y_i=0 SHALL move the FSM to CAPTURE; that pixel is processed as a CAPTURE pixel.
REQ-013 In CAPTURE, every pixel with de_i=1 inside the window SHALL be written; pixels with de_i=0 or outside the window SHALL NOT be written.
REQ-014 In CAPTURE, de_i=1 at (X_OFF+RES-1, Y_OFF+RES-1) SHALL move the FSM to DONE once that pixel's write has completed (write at N+2; done_o=1 from N+3).
REQ-015 start_i in ARM or CAPTURE SHALL be ignored.
REQ-016 A new frame start (0,0) seen in CAPTURE SHALL NOT restart capture; writes continue at the incoming addresses.
REQ-017 busy_o SHALL be 1 exactly in ARM and CAPTURE; done_o SHALL be 1 exactly in DONE.
REQ-018 Readback: rd_req_i in IDLE or DONE SHALL give rd_valid_o=1 with rd_data_o = buffer[rd_addr_i] on the next cycle.
REQ-019 rd_req_i in ARM or CAPTURE SHALL be dropped: rd_valid_o stays 0.
REQ-020 When start_i and rd_req_i coincide in DONE, the read SHALL be serviced with pre-capture data and the FSM SHALL enter ARM.
REQ-021 rd_data_o SHALL hold its last value when rd_valid_o=0.

Reset
REQ-022 rst_ni=0 SHALL asynchronously force IDLE, busy_o=0, done_o=0, rd_valid_o=0, rd_data_o=0 and clear all pipeline write-enables.
REQ-023 Buffer contents SHALL NOT be reset; a reset during CAPTURE keeps the partially written data and no pending write completes.
REQ-024 After reset release the FSM SHALL remain in IDLE until start_i.

Verification
REQ-025 The bench SHALL cover these scenarios:
- start_i, then a 640x480 frame of constant (r,g,b)=(40,80,120) -> after DONE every address reads 80; done_o rises 3 cycles after pixel (275,275).
- Gradient frame with red=green=blue=x_i[7:0] -> rd_addr 0 reads 20; rd_addr 255 reads 19 (275 mod 256); rd_addr 256 reads 20.
- de_i=0 over the whole window for one frame -> FSM stays CAPTURE, busy_o=1, no buffer write.
- Reset pulse at pixel (100,100) of a capture -> busy_o=0 immediately; rd_addr 0 returns the new data; rows at y>=81 return the previous contents.
- rd_req_i during CAPTURE -> rd_valid_o stays 0; start_i with rd_req_i in DONE -> rd_valid_o=1 next cycle with old data, busy_o=1.
- Pixels at x=19 and x=276 inside the row range -> never written (pre-filled 0xAA retained at adjacent addresses).
